// File: rtl/cle364_key_reader_if.sv
// ---------------------------------------------------------------------------
// cle364_key_reader_if
//   Host handshake plus PAL bus signals of the CLE364 key reader, bundled so
//   the sequencer and its user connect through one port.
//
//   Host side : start, cmd[3:0], abort, data_ready  (into the reader)
//               busy, data[BITS-1:0], data_valid    (out of the reader)
//   PAL side  : sser_n, ba[9:0] (BA13..BA4), br_w   (out of the reader)
//               sdrd                                (into the reader)
//
//   slave  : the reader itself
//   master : whatever drives requests and models the PAL
//   BITS must equal the BITS parameter of the reader it connects to.
// ---------------------------------------------------------------------------
interface cle364_key_reader_if #(
   parameter int BITS = 8
);
   logic            start;
   logic [3:0]      cmd;
   logic            abort;
   logic            busy;
   logic [BITS-1:0] data;
   logic            data_valid;
   logic            data_ready;
   logic            sser_n;
   logic [9:0]      ba;
   logic            br_w;
   logic            sdrd;

   modport slave (
      input  start, cmd, abort, data_ready, sdrd,
      output busy, data, data_valid, sser_n, ba, br_w
   );

   modport master (
      output start, cmd, abort, data_ready, sdrd,
      input  busy, data, data_valid, sser_n, ba, br_w
   );
endinterface

// File: rtl/cle364_key_reader.sv
// ---------------------------------------------------------------------------
// cle364_key_reader
//   Bus-side sequencer feeding the CLE364 key/sequence PAL. A start request
//   produces exactly BITS read strobes into the PAL decode window
//   (BA13=0, BA12=1, BR_W=1, SSER low); SDRD is sampled once per strobe and
//   the bits are assembled MSB-first into a word handed to the host with a
//   valid/ready handshake. The PAL only advances on strobes issued here.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : cle364_key_reader_if.slave
//              start/cmd/abort      request, address nibble, cancel
//              busy                 high outside IDLE
//              data/data_valid      assembled word, held until data_ready
//              sser_n/ba/br_w/sdrd  PAL strobe, address, direction, data
//
//   Parameters:
//     BITS        bits per word (2..16)
//     STROBE_CYC  clocks sser_n is low per bit (1..7)
//     RECOVER_CYC clocks sser_n is high between bits (1..7)
// ---------------------------------------------------------------------------
module cle364_key_reader #(
   parameter int BITS        = 8,
   parameter int STROBE_CYC  = 2,
   parameter int RECOVER_CYC = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   cle364_key_reader_if.slave bus
);

   localparam int               CNT_W        = $clog2(BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(BITS - 1);
   localparam logic [2:0]       STROBE_LOAD  = 3'(STROBE_CYC - 1);
   localparam logic [2:0]       RECOVER_LOAD = 3'(RECOVER_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      RECOVER,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       cyc_cnt;     // clocks left in the current STROBE/RECOVER
   logic [CNT_W-1:0] bit_cnt;     // bits already sampled in this word
   logic [BITS-2:0]  shift_q;     // earlier bits; the newest bit arrives via sdrd
   logic [BITS-1:0]  shift_nxt;
   logic [BITS-1:0]  data_q;
   logic [3:0]       cmd_q;
   logic [9:0]       addr;
   logic             start_acc;
   logic             phase_end;
   logic             sample;

   // Output-process results, forwarded to the interface below.
   logic             busy_o;
   logic             valid_o;
   logic             sser_n_o;
   logic [9:0]       ba_o;

   assign start_acc = (state == IDLE) && bus.start;
   assign phase_end = (cyc_cnt == 3'd0);
   // abort wins over the final strobe edge, so a cancelled bit is never kept.
   assign sample    = (state == STROBE) && phase_end && !bus.abort;
   assign shift_nxt = {shift_q, bus.sdrd};
   // BA13=0, BA12=1, BA11..BA8=0, BA7..BA4=cmd.
   assign addr      = {2'b01, 4'b0000, cmd_q};

   // ------------------------------------------------------------ state reg
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of block order.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      // NOTE: the default assignment up front keeps every path driven, so
      // no latch is inferred when a branch leaves state_nxt untouched.
      state_nxt = state;
      case (state)
         IDLE: begin
            // start beats a simultaneous abort here; abort is ignored in IDLE.
            if (bus.start) state_nxt = SETUP;
         end
         SETUP: begin
            state_nxt = bus.abort ? IDLE : STROBE;
         end
         STROBE: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (phase_end) begin
               state_nxt = (bit_cnt == LAST_BIT) ? DONE : RECOVER;
            end
         end
         RECOVER: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (phase_end) begin
               state_nxt = STROBE;
            end
         end
         DONE: begin
            // start in the same cycle as data_ready is not queued.
            if (bus.data_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      busy_o   = 1'b1;
      valid_o  = 1'b0;
      sser_n_o = 1'b1;
      ba_o     = '0;
      case (state)
         IDLE:    busy_o = 1'b0;
         SETUP:   ba_o   = addr;  // address settles a full clock before sser_n falls
         STROBE: begin
            ba_o     = addr;
            sser_n_o = 1'b0;
         end
         RECOVER: ba_o    = addr;
         DONE:    valid_o = 1'b1;
         default: busy_o  = 1'b0;
      endcase
   end

   assign bus.busy       = busy_o;
   assign bus.data_valid = valid_o;
   assign bus.sser_n     = sser_n_o;
   assign bus.ba         = ba_o;
   assign bus.br_w       = 1'b1;  // this block only ever reads the PAL
   assign bus.data       = data_q;

   // ------------------------------------------------- per-state cycle count
   // Reloaded on every state change, then counts down to zero; the phase
   // ends on the edge where the count is already zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt <= 3'd0;
      end else if (state_nxt != state) begin
         case (state_nxt)
            STROBE:  cyc_cnt <= STROBE_LOAD;
            RECOVER: cyc_cnt <= RECOVER_LOAD;
            default: cyc_cnt <= 3'd0;
         endcase
      end else if (cyc_cnt != 3'd0) begin
         cyc_cnt <= cyc_cnt - 3'd1;
      end
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shift register is small, so it is reset along with the
      // control state; the visible word must read 0 out of reset anyway.
      if (!rst_n) begin
         cmd_q   <= 4'd0;
         shift_q <= '0;
         bit_cnt <= '0;
         data_q  <= '0;
      end else if (start_acc) begin
         cmd_q   <= bus.cmd;
         shift_q <= '0;
         bit_cnt <= '0;
      end else if (sample) begin
         shift_q <= shift_nxt[BITS-2:0];
         bit_cnt <= bit_cnt + CNT_W'(1);
         // Publishing only a complete word lets an aborted read leave the
         // previous word visible.
         if (bit_cnt == LAST_BIT) data_q <= shift_nxt;
      end
   end

endmodule

// File: tb/tb_cle364_key_reader.sv
module tb_cle364_key_reader;

   localparam int A_BITS = 8;
   localparam int A_SC   = 2;
   localparam int A_RC   = 1;
   localparam int B_BITS = 4;
   localparam int B_SC   = 3;
   localparam int B_RC   = 2;
   localparam int A_LAT  = 1 + A_BITS * A_SC + (A_BITS - 1) * A_RC + 1;
   localparam int B_LAT  = 1 + B_BITS * B_SC + (B_BITS - 1) * B_RC + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cle364_key_reader_if #(.BITS(A_BITS)) bus_a ();
   cle364_key_reader_if #(.BITS(B_BITS)) bus_b ();

   cle364_key_reader #(.BITS(A_BITS), .STROBE_CYC(A_SC), .RECOVER_CYC(A_RC)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   cle364_key_reader #(.BITS(B_BITS), .STROBE_CYC(B_SC), .RECOVER_CYC(B_RC)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   // ---------------------------------------------------------------- PAL model
   // Each falling sser_n edge presents the next bit of the pattern on sdrd and
   // is counted; pulse widths, address during/before strobes and br_w are
   // tallied for the scenario tasks.
   bit         pat_a [16];
   bit         pat_b [16];
   int         fall_a, plen_bad_a, ba_bad_a, brw_bad_a, len_a;
   int         fall_b, plen_bad_b, ba_bad_b, brw_bad_b, len_b;
   logic       prev_sser_a, prev_sser_b;
   logic [9:0] prev_ba_a, prev_ba_b, exp_ba_a, exp_ba_b;

   always @(posedge clk) begin
      #2;
      if (bus_a.br_w !== 1'b1) brw_bad_a++;
      if (bus_a.sser_n === 1'b0) begin
         if (prev_sser_a === 1'b1) begin
            if (prev_ba_a !== exp_ba_a) ba_bad_a++;
            bus_a.sdrd = (fall_a < 16) ? pat_a[fall_a] : 1'b1;
            fall_a++;
            len_a = 0;
         end
         len_a++;
         if (bus_a.ba !== exp_ba_a) ba_bad_a++;
      end else if (prev_sser_a === 1'b0 && len_a != A_SC) begin
         plen_bad_a++;
      end
      prev_sser_a = bus_a.sser_n;
      prev_ba_a   = bus_a.ba;
   end

   always @(posedge clk) begin
      #2;
      if (bus_b.br_w !== 1'b1) brw_bad_b++;
      if (bus_b.sser_n === 1'b0) begin
         if (prev_sser_b === 1'b1) begin
            if (prev_ba_b !== exp_ba_b) ba_bad_b++;
            bus_b.sdrd = (fall_b < 16) ? pat_b[fall_b] : 1'b1;
            fall_b++;
            len_b = 0;
         end
         len_b++;
         if (bus_b.ba !== exp_ba_b) ba_bad_b++;
      end else if (prev_sser_b === 1'b0 && len_b != B_SC) begin
         plen_bad_b++;
      end
      prev_sser_b = bus_b.sser_n;
      prev_ba_b   = bus_b.ba;
   end

   // --------------------------------------------------------- reference model
   // Word = strobe bits in issue order, first bit weighted highest.
   function automatic int word_a();
      int w = 0;
      for (int i = 0; i < A_BITS; i++) w = w * 2 + int'(pat_a[i]);
      return w;
   endfunction

   function automatic int word_b();
      int w = 0;
      for (int i = 0; i < B_BITS; i++) w = w * 2 + int'(pat_b[i]);
      return w;
   endfunction

   // ------------------------------------------------------- stimulus helpers
   // Issue one start and count rising edges (accepting edge = 1) until
   // data_valid is seen; gives up after 200 edges.
   task automatic run_read_a(input logic [3:0] c, output int lat);
      @(negedge clk);
      fall_a = 0; plen_bad_a = 0; ba_bad_a = 0;
      exp_ba_a = {2'b01, 4'b0000, c};
      bus_a.cmd = c;
      bus_a.start = 1'b1;
      lat = 0;
      while (lat == 0 || (bus_a.data_valid !== 1'b1 && lat < 200)) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus_a.start = 1'b0;
      end
   endtask

   task automatic run_read_b(input logic [3:0] c, output int lat);
      @(negedge clk);
      fall_b = 0; plen_bad_b = 0; ba_bad_b = 0;
      exp_ba_b = {2'b01, 4'b0000, c};
      bus_b.cmd = c;
      bus_b.start = 1'b1;
      lat = 0;
      while (lat == 0 || (bus_b.data_valid !== 1'b1 && lat < 200)) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus_b.start = 1'b0;
      end
   endtask

   task automatic consume_a();
      @(negedge clk);
      bus_a.data_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.data_ready = 1'b0;
   endtask

   task automatic consume_b();
      @(negedge clk);
      bus_b.data_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_b.data_ready = 1'b0;
   endtask

   // -------------------------------------------------------------- scenarios
   task automatic test_reset();
      int w;
      #3;
      checks++;
      if ({bus_a.busy, bus_a.data_valid, bus_a.sser_n, bus_a.br_w} !== 4'b0011) begin
         failures++;
         $display("FAIL reset_ctrl_a: got %b expected 0011", {bus_a.busy, bus_a.data_valid, bus_a.sser_n, bus_a.br_w});
      end
      checks++;
      if (bus_a.ba !== 10'd0 || bus_a.data !== 8'd0) begin
         failures++;
         $display("FAIL reset_bus_a: ba=%h data=%h expected 0/0", bus_a.ba, bus_a.data);
      end
      checks++;
      if ({bus_b.busy, bus_b.data_valid, bus_b.sser_n, bus_b.br_w, bus_b.ba, bus_b.data} !== {4'b0011, 10'd0, 4'd0}) begin
         failures++;
         $display("FAIL reset_b: busy=%b dv=%b sser_n=%b br_w=%b ba=%h data=%h", bus_b.busy, bus_b.data_valid, bus_b.sser_n, bus_b.br_w, bus_b.ba, bus_b.data);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Reset dropped asynchronously in the middle of a strobe.
      for (int i = 0; i < 16; i++) pat_a[i] = 1'b1;
      exp_ba_a = 10'b01_0000_0101;
      @(negedge clk);
      bus_a.cmd = 4'h5;
      bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      w = 0;
      while (bus_a.sser_n !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 50) begin
         failures++;
         $display("FAIL reset_wait_strobe: sser_n never fell within %0d clks", w);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_a.busy, bus_a.data_valid, bus_a.sser_n} !== 3'b001 || bus_a.ba !== 10'd0) begin
         failures++;
         $display("FAIL reset_async: busy=%b dv=%b sser_n=%b ba=%h expected 0/0/1/000", bus_a.busy, bus_a.data_valid, bus_a.sser_n, bus_a.ba);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.sser_n !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: busy=%b sser_n=%b expected 0/1", bus_a.busy, bus_a.sser_n);
      end
   endtask

   task automatic test_default_read();
      int lat;
      bit p [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      for (int i = 0; i < 8; i++) pat_a[i] = p[i];
      run_read_a(4'hA, lat);
      checks++;
      if (lat != 25) begin
         failures++;
         $display("FAIL default_latency: got %0d clks expected 25", lat);
      end
      checks++;
      if (bus_a.data !== 8'hB2) begin
         failures++;
         $display("FAIL default_data: got %h expected b2", bus_a.data);
      end
      checks++;
      if (fall_a != 8 || plen_bad_a != 0) begin
         failures++;
         $display("FAIL default_strobes: falls=%0d bad_widths=%0d expected 8/0", fall_a, plen_bad_a);
      end
      checks++;
      if (ba_bad_a != 0 || bus_a.ba !== 10'd0) begin
         failures++;
         $display("FAIL default_address: bad=%0d ba_in_done=%h expected 0/000", ba_bad_a, bus_a.ba);
      end

      // Host stalls for 10 clocks; an abort in DONE must be ignored.
      for (int i = 0; i < 10; i++) begin
         bus_a.abort = (i == 3);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({bus_a.data_valid, bus_a.sser_n, bus_a.data} !== {2'b11, 8'hB2}) begin
            failures++;
            $display("FAIL hold_cycle%0d: dv=%b sser_n=%b data=%h expected 1/1/b2", i, bus_a.data_valid, bus_a.sser_n, bus_a.data);
         end
      end
      bus_a.abort = 1'b0;
      consume_a();
      checks++;
      if ({bus_a.busy, bus_a.data_valid, bus_a.data} !== {2'b00, 8'hB2}) begin
         failures++;
         $display("FAIL hold_release: busy=%b dv=%b data=%h expected 0/0/b2", bus_a.busy, bus_a.data_valid, bus_a.data);
      end
   endtask

   task automatic test_random_reads();
      int lat;
      int exp;
      logic [3:0] c;
      for (int n = 0; n < 4; n++) begin
         c = 4'($urandom_range(15, 0));
         for (int i = 0; i < 16; i++) pat_a[i] = bit'($urandom_range(1, 0));
         exp = word_a();
         run_read_a(c, lat);
         checks++;
         if (bus_a.data !== 8'(exp) || lat != A_LAT) begin
            failures++;
            $display("FAIL random%0d_word: data=%h lat=%0d expected %h/%0d", n, bus_a.data, lat, 8'(exp), A_LAT);
         end
         checks++;
         if (fall_a != A_BITS || ba_bad_a != 0 || plen_bad_a != 0) begin
            failures++;
            $display("FAIL random%0d_bus: falls=%0d ba_bad=%0d width_bad=%0d expected %0d/0/0", n, fall_a, ba_bad_a, plen_bad_a, A_BITS);
         end
         consume_a();
      end
   endtask

   task automatic test_abort();
      int w;
      int seen_dv;
      logic [7:0] prev_word;
      prev_word = bus_a.data;

      // Abort during the 4th strobe.
      for (int i = 0; i < 16; i++) pat_a[i] = bit'($urandom_range(1, 0));
      @(negedge clk);
      fall_a = 0;
      exp_ba_a = 10'b01_0000_0011;
      bus_a.cmd = 4'h3;
      bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      w = 0;
      while (fall_a < 4 && w < 100) begin
         @(negedge clk);
         w++;
      end
      bus_a.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.abort = 1'b0;
      checks++;
      if ({bus_a.busy, bus_a.sser_n, bus_a.data_valid} !== 3'b010 || bus_a.ba !== 10'd0) begin
         failures++;
         $display("FAIL abort_idle: busy=%b sser_n=%b dv=%b ba=%h expected 0/1/0/000", bus_a.busy, bus_a.sser_n, bus_a.data_valid, bus_a.ba);
      end
      seen_dv = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus_a.data_valid !== 1'b0) seen_dv++;
      end
      checks++;
      if (fall_a != 4 || seen_dv != 0) begin
         failures++;
         $display("FAIL abort_strobes: falls=%0d dv_cycles=%0d expected 4/0", fall_a, seen_dv);
      end
      checks++;
      if (bus_a.data !== prev_word) begin
         failures++;
         $display("FAIL abort_data_kept: got %h expected %h", bus_a.data, prev_word);
      end

      // Abort in SETUP: no strobe at all.
      fall_a = 0;
      bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_a.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.abort = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || fall_a != 0) begin
         failures++;
         $display("FAIL abort_setup: busy=%b falls=%0d expected 0/0", bus_a.busy, fall_a);
      end
   endtask

   task automatic test_ignored_start();
      int n;
      int words;
      int exp;
      for (int i = 0; i < 16; i++) pat_a[i] = bit'($urandom_range(1, 0));
      exp = word_a();

      // start together with abort in IDLE: the read starts.
      @(negedge clk);
      fall_a = 0; ba_bad_a = 0;
      exp_ba_a = 10'b01_0000_1100;
      bus_a.cmd = 4'hC;
      bus_a.start = 1'b1;
      bus_a.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.abort = 1'b0;
      bus_a.start = 1'b0;
      checks++;
      if (bus_a.busy !== 1'b1) begin
         failures++;
         $display("FAIL start_with_abort: busy=%b expected 1", bus_a.busy);
      end

      // Pulse start repeatedly while busy, with a different cmd.
      n = 0;
      words = 0;
      while (bus_a.data_valid !== 1'b1 && n < 200) begin
         bus_a.start = (n % 3 == 0);
         bus_a.cmd = 4'h1;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (bus_a.data_valid === 1'b1) words++;
      checks++;
      if (bus_a.data !== 8'(exp) || fall_a != A_BITS || ba_bad_a != 0) begin
         failures++;
         $display("FAIL busy_start_word: data=%h falls=%0d ba_bad=%0d expected %h/%0d/0", bus_a.data, fall_a, ba_bad_a, 8'(exp), A_BITS);
      end

      // data_ready and start together in DONE: the start is dropped.
      bus_a.start = 1'b1;
      bus_a.data_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_a.data_ready = 1'b0;
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.data_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: busy=%b dv=%b expected 0/0", bus_a.busy, bus_a.data_valid);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_a.data_valid === 1'b1) words++;
      end
      checks++;
      if (words != 1 || fall_a != A_BITS || bus_a.busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_word_count: words=%0d falls=%0d busy=%b expected 1/%0d/0", words, fall_a, bus_a.busy, A_BITS);
      end
   endtask

   task automatic test_param_sweep();
      int lat;
      int exp;
      logic [3:0] c;
      for (int i = 0; i < 16; i++) pat_b[i] = 1'b1;
      c = 4'($urandom_range(15, 0));
      run_read_b(c, lat);
      checks++;
      if (bus_b.data !== 4'hF || lat != 20) begin
         failures++;
         $display("FAIL sweep_ones: data=%h lat=%0d expected f/20", bus_b.data, lat);
      end
      checks++;
      if (fall_b != 4 || plen_bad_b != 0 || ba_bad_b != 0) begin
         failures++;
         $display("FAIL sweep_bus: falls=%0d width_bad=%0d ba_bad=%0d expected 4/0/0", fall_b, plen_bad_b, ba_bad_b);
      end
      consume_b();
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 16; i++) pat_b[i] = bit'($urandom_range(1, 0));
         exp = word_b();
         c = 4'($urandom_range(15, 0));
         run_read_b(c, lat);
         checks++;
         if (bus_b.data !== 4'(exp) || lat != B_LAT || fall_b != B_BITS) begin
            failures++;
            $display("FAIL sweep_random%0d: data=%h lat=%0d falls=%0d expected %h/%0d/%0d", n, bus_b.data, lat, fall_b, 4'(exp), B_LAT, B_BITS);
         end
         consume_b();
      end
   endtask

   task automatic test_read_only();
      checks++;
      if (brw_bad_a != 0 || brw_bad_b != 0) begin
         failures++;
         $display("FAIL br_w_low: cycles_a=%0d cycles_b=%0d expected 0/0", brw_bad_a, brw_bad_b);
      end
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.cmd = 4'd0; bus_a.abort = 1'b0;
      bus_a.data_ready = 1'b0; bus_a.sdrd = 1'b1;
      bus_b.start = 1'b0; bus_b.cmd = 4'd0; bus_b.abort = 1'b0;
      bus_b.data_ready = 1'b0; bus_b.sdrd = 1'b1;
      exp_ba_a = '0;
      exp_ba_b = '0;
      rst_n = 1'b0;

      test_reset();
      test_default_read();
      test_random_reads();
      test_abort();
      test_ignored_start();
      test_param_sweep();
      test_read_only();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
